// File: rtl/reg_read.sv
// reg_read: register file with a zero entry 0 and a 3-state operand read handshake (IDLE -> FETCH -> VALID).
module reg_read #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              rd_ack,
    output logic [DATA_W-1:0] Rd1,
    output logic [DATA_W-1:0] Rd2,
    output logic              rd_valid,
    output logic              rd_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
    state_t state, nxt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] a1, a2;
    logic byp1, byp2;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state == IDLE  ? (rd_req ? FETCH : IDLE) :
              state == FETCH ? VALID :
                               (rd_ack ? IDLE : VALID);
        byp1 = wr_en && wr_addr == a1 && a1 != '0;
        byp2 = wr_en && wr_addr == a2 && a2 != '0;
    end
    assign rd_valid = state == VALID;
    assign rd_busy  = state != IDLE;
    // entry 0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            a1  <= '0;
            a2  <= '0;
            Rd1 <= '0;
            Rd2 <= '0;
        end else begin
            if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
            if (state == IDLE && rd_req) begin
                a1 <= rd_addr1;
                a2 <= rd_addr2;
            end
            if (state == FETCH) begin
                Rd1 <= byp1 ? wr_data : regs[a1];
                Rd2 <= byp2 ? wr_data : regs[a2];
            end
        end
endmodule
